// File: rtl/alu_rs_scheduler_if.sv
// Shared types and the bus interface for the ALU reservation station.
// alu_rs_pkg holds the ALU op encoding and the reservation_station_t payload
// exchanged with rename/dispatch and alu_unit.
//
// Handshake: a dispatch transfer happens on a rising clk edge where
// dispatch_valid && dispatch_ready are both high; dispatch_ready never
// depends on dispatch_valid. alu_ready is a plain per-cycle "can accept"
// qualifier for the registered next_execute issue.

package alu_rs_pkg;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 4;

    typedef enum logic [3:0] {
        alu_op_add  = 4'd0,
        alu_op_sub  = 4'd1,
        alu_op_and  = 4'd2,
        alu_op_or   = 4'd3,
        alu_op_xor  = 4'd4,
        alu_op_sll  = 4'd5,
        alu_op_srl  = 4'd6,
        alu_op_sra  = 4'd7,
        alu_op_slt  = 4'd8,
        alu_op_sltu = 4'd9,
        alu_op_lui  = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic              valid;
        alu_op_t           alu_op;
        logic [PREG_W-1:0] rd_paddr;
        logic [ROB_W-1:0]  rd_rob_idx;
        logic [PREG_W-1:0] rs1_paddr;
        logic [31:0]       rs1_data;
        logic [PREG_W-1:0] rs2_paddr;
        logic [31:0]       rs2_data;
    } reservation_station_t;
endpackage

interface alu_rs_scheduler_if #(
    parameter int DEPTH = 8
);
    import alu_rs_pkg::*;

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    reservation_station_t dispatch_entry;
    logic                 dispatch_rs1_rdy;
    logic                 dispatch_rs2_rdy;
    logic                 cdb_valid;
    logic [PREG_W-1:0]    cdb_paddr;
    logic [31:0]          cdb_data;
    logic [ROB_W-1:0]     rob_head;
    logic                 alu_ready;
    reservation_station_t next_execute;
    logic [OCC_W-1:0]     occupancy;

    // Pipeline side: dispatch, CDB, ROB head and ALU backpressure.
    modport master (
        output flush, dispatch_valid, dispatch_entry, dispatch_rs1_rdy,
               dispatch_rs2_rdy, cdb_valid, cdb_paddr, cdb_data, rob_head,
               alu_ready,
        input  dispatch_ready, next_execute, occupancy
    );

    // Reservation station side.
    modport slave (
        input  flush, dispatch_valid, dispatch_entry, dispatch_rs1_rdy,
               dispatch_rs2_rdy, cdb_valid, cdb_paddr, cdb_data, rob_head,
               alu_ready,
        output dispatch_ready, next_execute, occupancy
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station and oldest-first issue scheduler.
// Buffers dispatched ops, wakes operands from the CDB, and registers the
// oldest fully-ready op (modular ROB age) into next_execute each cycle.
// Optional feature macro: ALU_RS_WAKEUP_BYPASS_EN -- when defined, a CDB
// match counts as ready in the same cycle and its data is muxed into the
// issued payload (back-to-back dependent issue).

module alu_rs_scheduler
    import alu_rs_pkg::reservation_station_t;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 4
) (
    input logic              clk,
    input logic              rst,
    alu_rs_scheduler_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    // slot[i].valid doubles as the per-slot valid bit.
    reservation_station_t slot [DEPTH];
    logic [DEPTH-1:0]     rs1_rdy;
    logic [DEPTH-1:0]     rs2_rdy;
    logic [OCC_W-1:0]     occ;
    reservation_station_t ne_q;

    logic [PREG_W-1:0]    cdb_tag;
    logic                 cdb_hit;
    logic [DEPTH-1:0]     wake1;
    logic [DEPTH-1:0]     wake2;
    logic [DEPTH-1:0]     cand;
    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [ROB_W-1:0]     sel_age;
    logic [ROB_W-1:0]     age;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 issue;
    logic                 do_dispatch;
    logic                 disp_wake1;
    logic                 disp_wake2;
    reservation_station_t issue_payload;
    reservation_station_t disp_payload;

    assign cdb_tag = bus.cdb_paddr;
    // p0 is the hardwired zero register and never carries a wakeup.
    assign cdb_hit = bus.cdb_valid && (cdb_tag != '0);

    // Per-slot CDB wakeup match and select candidacy.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        cand  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = slot[i].valid && !rs1_rdy[i] && cdb_hit && (slot[i].rs1_paddr == cdb_tag);
            wake2[i] = slot[i].valid && !rs2_rdy[i] && cdb_hit && (slot[i].rs2_paddr == cdb_tag);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            cand[i] = slot[i].valid && (rs1_rdy[i] || wake1[i]) && (rs2_rdy[i] || wake2[i]);
`else
            cand[i] = slot[i].valid && rs1_rdy[i] && rs2_rdy[i];
`endif
        end
    end

    // Oldest-candidate select; strict less-than keeps ties on the lowest slot.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_age = '0;
        age     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = slot[i].rd_rob_idx - bus.rob_head;
            if (cand[i] && (!found || (age < sel_age))) begin
                found   = 1'b1;
                sel     = IDX_W'(i);
                sel_age = age;
            end
        end
    end

    // Issued payload, with CDB data forwarded for operands woken this cycle.
    always_comb begin
        issue_payload       = slot[sel];
        issue_payload.valid = 1'b1;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        if (wake1[sel]) issue_payload.rs1_data = bus.cdb_data;
        if (wake2[sel]) issue_payload.rs2_data = bus.cdb_data;
`endif
    end

    // Lowest free slot and the dispatch write payload with same-cycle snoop.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!slot[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        disp_wake1 = !bus.dispatch_rs1_rdy && cdb_hit && (bus.dispatch_entry.rs1_paddr == cdb_tag);
        disp_wake2 = !bus.dispatch_rs2_rdy && cdb_hit && (bus.dispatch_entry.rs2_paddr == cdb_tag);
        disp_payload       = bus.dispatch_entry;
        disp_payload.valid = 1'b1;
        if (disp_wake1) disp_payload.rs1_data = bus.cdb_data;
        if (disp_wake2) disp_payload.rs2_data = bus.cdb_data;
    end

    // A slot being issued still looks valid this cycle, so it is not reused
    // until the next one; flush discards both dispatch and issue.
    assign bus.dispatch_ready = (occ < OCC_W'(DEPTH));
    assign do_dispatch = bus.dispatch_valid && bus.dispatch_ready && free_found && !bus.flush;
    assign issue       = bus.alu_ready && found && !bus.flush;

    assign bus.next_execute = ne_q;
    assign bus.occupancy    = occ;

    // Slot state, issue register and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
            occ     <= '0;
            ne_q    <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) slot[i].valid <= 1'b0;
            occ  <= '0;
            ne_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i]) begin
                    slot[i].rs1_data <= bus.cdb_data;
                    rs1_rdy[i]       <= 1'b1;
                end
                if (wake2[i]) begin
                    slot[i].rs2_data <= bus.cdb_data;
                    rs2_rdy[i]       <= 1'b1;
                end
            end
            if (issue) begin
                ne_q             <= issue_payload;
                slot[sel].valid  <= 1'b0;
            end else begin
                ne_q <= '0;
            end
            if (do_dispatch) begin
                slot[free_idx]    <= disp_payload;
                rs1_rdy[free_idx] <= bus.dispatch_rs1_rdy || disp_wake1;
                rs2_rdy[free_idx] <= bus.dispatch_rs2_rdy || disp_wake2;
            end
            occ <= occ + OCC_W'(do_dispatch) - OCC_W'(issue);
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.

module tb_alu_rs_scheduler;
    import alu_rs_pkg::*;

    localparam int DEPTH = 8;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    localparam bit BYP      = 1'b1;
    localparam int WAKE_LAT = 1;
`else
    localparam bit BYP      = 1'b0;
    localparam int WAKE_LAT = 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rs_scheduler_if #(.DEPTH(DEPTH)) bus();

    alu_rs_scheduler #(.DEPTH(DEPTH), .PREG_W(6), .ROB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    typedef struct {
        reservation_station_t p;
        logic                 r1;
        logic                 r2;
    } ment_t;

    ment_t                model_q[$];
    reservation_station_t exp_ne;
    logic [3:0]           exp_q[$];

    // One clock of the model: oldest ready op leaves, CDB wakes the rest,
    // the dispatched op joins if there was room before this edge.
    task automatic model_step();
        int                   best;
        int                   n_before;
        logic [3:0]           best_age;
        logic [3:0]           a;
        bit                   hit;
        bit                   w1;
        bit                   w2;
        ment_t                e;
        reservation_station_t ne;
        if (rst || bus.flush) begin
            model_q.delete();
            exp_ne = '0;
            return;
        end
        n_before = model_q.size();
        hit      = bus.cdb_valid && (bus.cdb_paddr != 0);
        best     = -1;
        best_age = '0;
        for (int i = 0; i < model_q.size(); i++) begin
            e  = model_q[i];
            w1 = hit && !e.r1 && (e.p.rs1_paddr == bus.cdb_paddr);
            w2 = hit && !e.r2 && (e.p.rs2_paddr == bus.cdb_paddr);
            if ((e.r1 || (BYP && w1)) && (e.r2 || (BYP && w2))) begin
                a = e.p.rd_rob_idx - bus.rob_head;
                if (best < 0 || a < best_age) begin
                    best     = i;
                    best_age = a;
                end
            end
        end
        ne = '0;
        if (bus.alu_ready && best >= 0) begin
            e        = model_q[best];
            ne       = e.p;
            ne.valid = 1'b1;
            if (!e.r1) ne.rs1_data = bus.cdb_data;
            if (!e.r2) ne.rs2_data = bus.cdb_data;
            model_q.delete(best);
        end
        for (int i = 0; i < model_q.size(); i++) begin
            e = model_q[i];
            if (hit && !e.r1 && e.p.rs1_paddr == bus.cdb_paddr) begin
                e.r1 = 1'b1;
                e.p.rs1_data = bus.cdb_data;
            end
            if (hit && !e.r2 && e.p.rs2_paddr == bus.cdb_paddr) begin
                e.r2 = 1'b1;
                e.p.rs2_data = bus.cdb_data;
            end
            model_q[i] = e;
        end
        if (bus.dispatch_valid && n_before < DEPTH) begin
            e.p       = bus.dispatch_entry;
            e.p.valid = 1'b1;
            e.r1      = bus.dispatch_rs1_rdy;
            e.r2      = bus.dispatch_rs2_rdy;
            if (hit && !e.r1 && e.p.rs1_paddr == bus.cdb_paddr) begin
                e.r1 = 1'b1;
                e.p.rs1_data = bus.cdb_data;
            end
            if (hit && !e.r2 && e.p.rs2_paddr == bus.cdb_paddr) begin
                e.r2 = 1'b1;
                e.p.rs2_data = bus.cdb_data;
            end
            model_q.push_back(e);
        end
        exp_ne = ne;
    endtask

    // Compare process: step the model on each edge, check 1 time unit later.
    initial begin
        exp_ne = '0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("next_execute", bus.next_execute, exp_ne);
            check("occupancy", bus.occupancy, model_q.size());
            check("dispatch_ready", bus.dispatch_ready, model_q.size() < DEPTH);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] rob, input logic [5:0] p1, input logic [31:0] d1,
                            input logic r1, input logic [5:0] p2, input logic [31:0] d2,
                            input logic r2, input logic [3:0] op, input logic vbit);
        reservation_station_t e;
        e            = '0;
        e.valid      = vbit;
        e.alu_op     = alu_op_t'(op);
        e.rd_paddr   = {2'b10, rob};
        e.rd_rob_idx = rob;
        e.rs1_paddr  = p1;
        e.rs1_data   = d1;
        e.rs2_paddr  = p2;
        e.rs2_data   = d2;
        bus.dispatch_entry   = e;
        bus.dispatch_rs1_rdy = r1;
        bus.dispatch_rs2_rdy = r2;
        bus.dispatch_valid   = 1'b1;
    endtask

    task automatic set_cdb(input logic [5:0] paddr, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_paddr = paddr;
        bus.cdb_data  = data;
    endtask

    function automatic logic [3:0] pick_rob();
        logic [3:0] r;
        bit         used;
        r = '0;
        for (int t = 0; t < 64; t++) begin
            r    = 4'($urandom_range(0, 15));
            used = 1'b0;
            foreach (model_q[i]) if (model_q[i].p.rd_rob_idx == r) used = 1'b1;
            if (!used) return r;
        end
        return r;
    endfunction

    task automatic rand_dispatch();
        logic       r1;
        logic       r2;
        logic [5:0] p1;
        logic [5:0] p2;
        r1 = 1'($urandom_range(0, 1));
        r2 = 1'($urandom_range(0, 1));
        p1 = r1 ? 6'($urandom_range(0, 15)) : 6'($urandom_range(1, 15));
        p2 = r2 ? 6'($urandom_range(0, 15)) : 6'($urandom_range(1, 15));
        set_disp(pick_rob(), p1, $urandom, r1, p2, $urandom, r2,
                 4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] fill_order [8];
        logic [3:0] wrap_robs [3];
        int         n;
        fill_order = '{4'd3, 4'd0, 4'd7, 4'd1, 4'd5, 4'd2, 4'd6, 4'd4};
        wrap_robs  = '{4'd1, 4'd15, 4'd14};

        clear_in();
        bus.dispatch_entry   = '0;
        bus.dispatch_rs1_rdy = 1'b0;
        bus.dispatch_rs2_rdy = 1'b0;
        bus.cdb_paddr        = '0;
        bus.cdb_data         = '0;
        bus.rob_head         = '0;
        bus.alu_ready        = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("reset_occ", bus.occupancy, 0);
        check("reset_dready", bus.dispatch_ready, 1);
        check("reset_ne", bus.next_execute, 0);

        // Basic issue: add with rs1=5, rs2=7 ready
        bus.alu_ready = 1'b1;
        set_disp(4'd0, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7, 1'b1, 4'd0, 1'b0);
        tick();
        clear_in();
        check("basic_occ1", bus.occupancy, 1);
        check("basic_noissue", bus.next_execute.valid, 0);
        tick();
        check("basic_valid", bus.next_execute.valid, 1);
        check("basic_rs1", bus.next_execute.rs1_data, 5);
        check("basic_rs2", bus.next_execute.rs2_data, 7);
        check("basic_op", bus.next_execute.alu_op, alu_op_add);
        check("basic_occ0", bus.occupancy, 0);
        tick();

        // alu_ready backpressure
        bus.alu_ready = 1'b0;
        set_disp(4'd6, 6'd1, 32'd11, 1'b1, 6'd2, 32'd22, 1'b1, 4'd1, 1'b1);
        tick();
        clear_in();
        repeat (3) begin
            check("bp_hold", bus.next_execute.valid, 0);
            tick();
        end
        bus.alu_ready = 1'b1;
        tick();
        check("bp_issue", bus.next_execute.valid, 1);
        check("bp_rob", bus.next_execute.rd_rob_idx, 6);
        tick();

        // Fill to full, all waiting on p12
        for (int k = 0; k < 8; k++) begin
            set_disp(fill_order[k], 6'd12, 32'd0, 1'b0, 6'd3, 32'(100 + k), 1'b1, 4'd2, 1'b0);
            tick();
        end
        clear_in();
        check("full_occ", bus.occupancy, 8);
        check("full_dready", bus.dispatch_ready, 0);
        check("full_noissue", bus.next_execute.valid, 0);
        set_disp(4'd8, 6'd1, 32'd1, 1'b1, 6'd1, 32'd1, 1'b1, 4'd0, 1'b1);
        tick();
        clear_in();
        check("full_reject", bus.occupancy, 8);
        set_cdb(6'd12, 32'hDEAD);
        tick();
        clear_in();
        n = 1;
        while (!bus.next_execute.valid && n < 4) begin
            tick();
            n++;
        end
        check("fill_wake_lat", n, WAKE_LAT);
        for (int k = 0; k < 8; k++) exp_q.push_back(4'(k));
        for (int k = 0; k < 8; k++) begin
            check("fill_valid", bus.next_execute.valid, 1);
            check("fill_order", bus.next_execute.rd_rob_idx, exp_q.pop_front());
            check("fill_data", bus.next_execute.rs1_data, 32'hDEAD);
            tick();
        end
        check("fill_drained", bus.next_execute.valid, 0);
        check("fill_occ0", bus.occupancy, 0);

        // Age wrap: head 14, robs 1, 15, 14 -> 14, 15, 1
        bus.alu_ready = 1'b0;
        bus.rob_head  = 4'd14;
        for (int k = 0; k < 3; k++) begin
            set_disp(wrap_robs[k], 6'd1, 32'(k), 1'b1, 6'd2, 32'd0, 1'b1, 4'd3, 1'b0);
            tick();
        end
        clear_in();
        bus.alu_ready = 1'b1;
        exp_q = '{4'd14, 4'd15, 4'd1};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wrap_valid", bus.next_execute.valid, 1);
            check("wrap_order", bus.next_execute.rd_rob_idx, exp_q.pop_front());
        end
        tick();
        bus.rob_head = 4'd0;

        // Dispatch and CDB on the same operand in the same cycle
        set_disp(4'd2, 6'd9, 32'd0, 1'b0, 6'd4, 32'd33, 1'b1, 4'd4, 1'b0);
        set_cdb(6'd9, 32'h1234);
        tick();
        clear_in();
        check("snoop_held", bus.occupancy, 1);
        tick();
        check("snoop_valid", bus.next_execute.valid, 1);
        check("snoop_data", bus.next_execute.rs1_data, 32'h1234);
        tick();

        // CDB on p0 wakes nothing
        set_disp(4'd3, 6'd0, 32'd0, 1'b0, 6'd4, 32'd1, 1'b1, 4'd5, 1'b0);
        tick();
        clear_in();
        set_cdb(6'd0, 32'h55);
        tick();
        clear_in();
        repeat (3) begin
            check("p0_nowake", bus.next_execute.valid, 0);
            tick();
        end
        check("p0_occ", bus.occupancy, 1);
        bus.flush = 1'b1;
        tick();
        clear_in();
        check("p0_flushed", bus.occupancy, 0);

        // Flush mid-operation with a simultaneous dispatch
        bus.alu_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_disp(4'(k), 6'd1, 32'(k), 1'b1, 6'd2, 32'(k), 1'b1, 4'd6, 1'b0);
            tick();
        end
        clear_in();
        check("flush_pre_occ", bus.occupancy, 5);
        set_disp(4'd5, 6'd1, 32'd9, 1'b1, 6'd2, 32'd9, 1'b1, 4'd6, 1'b1);
        set_cdb(6'd3, 32'h77);
        bus.flush     = 1'b1;
        bus.alu_ready = 1'b1;
        tick();
        clear_in();
        check("flush_occ", bus.occupancy, 0);
        check("flush_ne", bus.next_execute.valid, 0);
        repeat (4) begin
            tick();
            check("flush_quiet", bus.next_execute.valid, 0);
            check("flush_quiet_occ", bus.occupancy, 0);
        end

        // Equal age resolves to the lower slot (first dispatched into empty RS)
        bus.alu_ready = 1'b0;
        set_disp(4'd5, 6'd1, 32'hA, 1'b1, 6'd2, 32'd0, 1'b1, 4'd0, 1'b0);
        tick();
        set_disp(4'd5, 6'd1, 32'hB, 1'b1, 6'd2, 32'd0, 1'b1, 4'd0, 1'b0);
        tick();
        clear_in();
        bus.alu_ready = 1'b1;
        tick();
        check("tie_first", bus.next_execute.rs1_data, 32'hA);
        tick();
        check("tie_second", bus.next_execute.rs1_data, 32'hB);
        tick();

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 800; c++) begin
            bus.rob_head  = 4'($urandom_range(0, 15));
            bus.alu_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 99) < 2);
            bus.cdb_valid = ($urandom_range(0, 9) < 4);
            bus.cdb_paddr = 6'($urandom_range(0, 15));
            bus.cdb_data  = $urandom;
            if ($urandom_range(0, 9) < 6) rand_dispatch();
            else bus.dispatch_valid = 1'b0;
            tick();
        end
        clear_in();
        bus.flush = 1'b1;
        tick();
        clear_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
